// File: rtl/mr_pkg.sv
// ============================================================================
// Module      : mr_pkg
// Description : Shared MapReduce types and constants (mapper and reducer).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mr_pkg;

    localparam int DATA_SIZE   = 32;
    localparam int WORD_LENGTH = 128;

    localparam logic [7:0] c_delim_space = 8'h20;
    localparam logic [7:0] c_delim_tab   = 8'h09;
    localparam logic [7:0] c_delim_lf    = 8'h0A;
    localparam logic [7:0] c_delim_cr    = 8'h0D;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        EMIT    = 2'd1,
        GAP     = 2'd2
    } mapper_state_t;

    typedef logic [WORD_LENGTH-1:0] key_t;

    function automatic logic is_delim(input logic [7:0] ch);
        return (ch == c_delim_space) || (ch == c_delim_tab) ||
               (ch == c_delim_lf)    || (ch == c_delim_cr);
    endfunction

endpackage

`default_nettype wire

// File: rtl/word_packer.sv
// ============================================================================
// Module      : word_packer
// Description : Key register, length counter, truncation flag and beat mux.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module word_packer #(
    parameter int DATA_SIZE   = 32,
    parameter int WORD_LENGTH = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic                 i_append,
    input  logic [7:0]           i_char,
    input  logic [1:0]           i_beat_sel,
    output logic                 o_empty,
    output logic                 o_trunc,
    output logic [DATA_SIZE-1:0] o_beat
);

    localparam int c_max_chars = WORD_LENGTH / 8;
    localparam int c_len_w     = $clog2(c_max_chars + 1);
    localparam int c_beats     = WORD_LENGTH / DATA_SIZE;
    localparam logic [c_len_w-1:0] c_len_full = c_len_w'(c_max_chars);

    logic [WORD_LENGTH-1:0] r_key;
    logic [WORD_LENGTH-1:0] w_key_nxt;
    logic [c_len_w-1:0]     r_len;
    logic                   r_trunc;
    logic                   w_full;

    assign w_full  = (r_len == c_len_full);
    assign o_empty = (r_len == '0);
    assign o_trunc = r_trunc;

    // Characters arriving once the key is full leave it untouched.
    always_comb begin
        w_key_nxt = r_key;
        if (i_clear) begin
            w_key_nxt = '0;
        end else if (i_append) begin
            for (int k = 0; k < c_max_chars; k++) begin
                if (r_len == c_len_w'(k)) begin
                    w_key_nxt[8*k +: 8] = i_char;
                end
            end
        end
    end

    // The mux looks at the next key so a character appended in the same
    // cycle as a flush is already visible in beat 0.
    always_comb begin
        o_beat = '0;
        for (int b = 0; b < c_beats; b++) begin
            if (i_beat_sel == 2'(b)) begin
                o_beat = w_key_nxt[DATA_SIZE*b +: DATA_SIZE];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key   <= '0;
            r_len   <= '0;
            r_trunc <= 1'b0;
        end else begin
            r_key <= w_key_nxt;
            if (i_clear) begin
                r_len <= '0;
            end else if (i_append && !w_full) begin
                r_len <= r_len + 1'b1;
            end
            if (i_append && w_full) begin
                r_trunc <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/word_mapper.sv
// ============================================================================
// Module      : word_mapper
// Description : Splits a byte stream into words, emits each as 4 key beats.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module word_mapper #(
    parameter int DATA_SIZE   = mr_pkg::DATA_SIZE,
    parameter int WORD_LENGTH = mr_pkg::WORD_LENGTH,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           char_in,
    input  logic                 char_valid,
    output logic                 char_ready,
    input  logic                 flush,
    output logic                 write_out,
    output logic [DATA_SIZE-1:0] pair_out,
    output logic [7:0]           word_count,
    output logic                 trunc
);

    import mr_pkg::*;

    localparam logic [3:0] c_gap_last = 4'(GAP_CYCLES - 1);

    mapper_state_t          r_state;
    mapper_state_t          w_state_nxt;
    logic [1:0]             r_beat;
    logic [1:0]             w_beat_sel;
    logic [3:0]             r_gap;
    logic [7:0]             r_word_count;
    logic                   r_write_out;
    logic [DATA_SIZE-1:0]   r_pair_out;
    logic [DATA_SIZE-1:0]   w_beat;
    logic                   w_accept;
    logic                   w_delim;
    logic                   w_append;
    logic                   w_empty;
    logic                   w_has_word;
    logic                   w_clear;

    assign char_ready = (r_state == COLLECT);
    assign w_accept   = char_valid && char_ready;
    assign w_delim    = is_delim(char_in);
    assign w_append   = w_accept && !w_delim;
    assign w_has_word = !w_empty || w_append;
    assign w_clear    = (r_state == GAP) && (r_gap == c_gap_last);

    word_packer #(
        .DATA_SIZE   (DATA_SIZE),
        .WORD_LENGTH (WORD_LENGTH)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_clear),
        .i_append   (w_append),
        .i_char     (char_in),
        .i_beat_sel (w_beat_sel),
        .o_empty    (w_empty),
        .o_trunc    (trunc),
        .o_beat     (w_beat)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_beat_sel  = 2'd0;
        case (r_state)
            COLLECT: begin
                if (((w_accept && w_delim) || flush) && w_has_word) begin
                    w_state_nxt = EMIT;
                end
            end
            EMIT: begin
                w_beat_sel = r_beat + 2'd1;
                if (r_beat == 2'd3) begin
                    w_state_nxt = GAP;
                end
            end
            GAP: begin
                if (r_gap == c_gap_last) begin
                    w_state_nxt = COLLECT;
                end
            end
            default: w_state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= COLLECT;
            r_beat       <= 2'd0;
            r_gap        <= 4'd0;
            r_word_count <= 8'd0;
            r_write_out  <= 1'b0;
            r_pair_out   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_write_out <= (w_state_nxt == EMIT);
            r_pair_out  <= (w_state_nxt == EMIT) ? w_beat : '0;
            r_beat      <= (r_state == EMIT) ? r_beat + 2'd1 : 2'd0;
            r_gap       <= (r_state == GAP) ? r_gap + 4'd1 : 4'd0;
            if ((r_state == EMIT) && (r_beat == 2'd3)) begin
                r_word_count <= r_word_count + 8'd1;
            end
        end
    end

    assign write_out  = r_write_out;
    assign pair_out   = r_pair_out;
    assign word_count = r_word_count;

endmodule

`default_nettype wire

// File: tb/tb_word_mapper.sv
// ============================================================================
// Module      : tb_word_mapper
// Description : Directed self-checking bench for word_mapper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_word_mapper;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  char_in;
    logic        char_valid;
    logic        flush;
    logic        char_ready;
    logic        write_out;
    logic [31:0] pair_out;
    logic [7:0]  word_count;
    logic        trunc;

    logic [7:0]  c1_char;
    logic        c1_valid;
    logic        c1_flush;
    logic        c1_ready;
    logic        c1_write;
    logic [31:0] c1_pair;
    logic [7:0]  c1_count;
    logic        c1_trunc;

    word_mapper #(.DATA_SIZE(32), .WORD_LENGTH(128), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .char_in(char_in), .char_valid(char_valid),
        .char_ready(char_ready), .flush(flush), .write_out(write_out),
        .pair_out(pair_out), .word_count(word_count), .trunc(trunc)
    );

    word_mapper #(.DATA_SIZE(32), .WORD_LENGTH(128), .GAP_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .char_in(c1_char), .char_valid(c1_valid),
        .char_ready(c1_ready), .flush(c1_flush), .write_out(c1_write),
        .pair_out(c1_pair), .word_count(c1_count), .trunc(c1_trunc)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          low_run = 0;
    int          min_gap = 1000;
    bit          had_burst = 1'b0;

    // Beat collectors; min_gap records the shortest idle run between bursts.
    always @(negedge clk) begin
        if (write_out) begin
            if (had_burst && low_run > 0 && low_run < min_gap) min_gap = low_run;
            had_burst = 1'b1;
            low_run   = 0;
            q0.push_back(pair_out);
        end else begin
            low_run++;
        end
        if (c1_write) q1.push_back(c1_pair);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        char_in    = b;
        char_valid = 1'b1;
        while (!char_ready && t < 100) begin
            step();
            t++;
        end
        n_cmp++;
        if (char_ready !== 1'b1) begin
            n_err++;
            $display("FAIL send_timeout: char_ready=%b required 1", char_ready);
        end
        step();
        char_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic test_reset();
        rst = 1'b1; char_valid = 1'b0; flush = 1'b0; char_in = 8'h00;
        c1_valid = 1'b0; c1_flush = 1'b0; c1_char = 8'h00;
        repeat (3) step();
        n_cmp++; if (write_out !== 1'b0) begin n_err++; $display("FAIL reset_write_out: got %b want 0", write_out); end
        n_cmp++; if (pair_out !== 32'h0) begin n_err++; $display("FAIL reset_pair_out: got %h want 0", pair_out); end
        n_cmp++; if (word_count !== 8'd0) begin n_err++; $display("FAIL reset_word_count: got %0d want 0", word_count); end
        n_cmp++; if (trunc !== 1'b0) begin n_err++; $display("FAIL reset_trunc: got %b want 0", trunc); end
        rst = 1'b0;
        step();
        n_cmp++; if (char_ready !== 1'b1) begin n_err++; $display("FAIL reset_char_ready: got %b want 1", char_ready); end
    endtask

    task automatic test_hi();
        logic [31:0] exp_beat [4] = '{32'h00006968, 32'h0, 32'h0, 32'h0};
        send_str("hi ");
        for (int b = 0; b < 4; b++) begin
            n_cmp++; if (write_out !== 1'b1) begin n_err++; $display("FAIL hi_write_beat%0d: got %b want 1", b, write_out); end
            n_cmp++; if (pair_out !== exp_beat[b]) begin n_err++; $display("FAIL hi_pair_beat%0d: got %h want %h", b, pair_out, exp_beat[b]); end
            n_cmp++; if (char_ready !== 1'b0) begin n_err++; $display("FAIL hi_ready_beat%0d: got %b want 0", b, char_ready); end
            step();
        end
        for (int g = 0; g < 2; g++) begin
            n_cmp++; if (write_out !== 1'b0) begin n_err++; $display("FAIL hi_write_gap%0d: got %b want 0", g, write_out); end
            n_cmp++; if (pair_out !== 32'h0) begin n_err++; $display("FAIL hi_pair_gap%0d: got %h want 0", g, pair_out); end
            n_cmp++; if (char_ready !== 1'b0) begin n_err++; $display("FAIL hi_ready_gap%0d: got %b want 0", g, char_ready); end
            step();
        end
        n_cmp++; if (char_ready !== 1'b1) begin n_err++; $display("FAIL hi_ready_after: got %b want 1", char_ready); end
        n_cmp++; if (word_count !== 8'd1) begin n_err++; $display("FAIL hi_word_count: got %0d want 1", word_count); end
        n_cmp++; if (trunc !== 1'b0) begin n_err++; $display("FAIL hi_trunc: got %b want 0", trunc); end
    endtask

    task automatic test_trunc();
        logic [31:0] exp_beat [4] = '{32'h64636261, 32'h68676665, 32'h6c6b6a69, 32'h706f6e6d};
        send_str("abcdefghijklmnopqrs ");
        for (int b = 0; b < 4; b++) begin
            n_cmp++; if (pair_out !== exp_beat[b] || write_out !== 1'b1) begin
                n_err++; $display("FAIL trunc_beat%0d: got %h/%b want %h/1", b, pair_out, write_out, exp_beat[b]);
            end
            step();
        end
        repeat (3) step();
        n_cmp++; if (trunc !== 1'b1) begin n_err++; $display("FAIL trunc_flag: got %b want 1", trunc); end
        n_cmp++; if (word_count !== 8'd2) begin n_err++; $display("FAIL trunc_word_count: got %0d want 2", word_count); end
    endtask

    task automatic test_multi_delim();
        q0.delete(); had_burst = 1'b0; min_gap = 1000;
        send_str("  a   b\n");
        repeat (10) step();
        n_cmp++; if (q0.size() != 8) begin n_err++; $display("FAIL md_beats: got %0d want 8", q0.size()); end
        if (q0.size() >= 8) begin
            n_cmp++; if (q0[0] !== 32'h00000061) begin n_err++; $display("FAIL md_word0: got %h want 00000061", q0[0]); end
            n_cmp++; if (q0[4] !== 32'h00000062) begin n_err++; $display("FAIL md_word1: got %h want 00000062", q0[4]); end
            for (int i = 1; i < 8; i++) begin
                if (i != 4) begin
                    n_cmp++; if (q0[i] !== 32'h0) begin n_err++; $display("FAIL md_upper%0d: got %h want 0", i, q0[i]); end
                end
            end
        end
        n_cmp++; if (min_gap < 2 || min_gap == 1000) begin n_err++; $display("FAIL md_gap: got %0d want >=2", min_gap); end
        n_cmp++; if (word_count !== 8'd4) begin n_err++; $display("FAIL md_word_count: got %0d want 4", word_count); end
    endtask

    task automatic test_flush();
        q0.delete();
        send_str("xy");
        flush = 1'b1; send_byte("z"); flush = 1'b0;
        repeat (8) step();
        n_cmp++; if (q0.size() != 4) begin n_err++; $display("FAIL fl_beats: got %0d want 4", q0.size()); end
        if (q0.size() >= 1) begin
            n_cmp++; if (q0[0] !== 32'h007a7978) begin n_err++; $display("FAIL fl_word: got %h want 007a7978", q0[0]); end
        end
        q0.delete();
        flush = 1'b1; step(); flush = 1'b0;
        repeat (8) step();
        n_cmp++; if (q0.size() != 0) begin n_err++; $display("FAIL fl_empty: got %0d beats want 0", q0.size()); end
        send_str("k");
        flush = 1'b1; send_byte(" "); flush = 1'b0;
        repeat (10) step();
        n_cmp++; if (q0.size() != 4) begin n_err++; $display("FAIL fl_delim_beats: got %0d want 4", q0.size()); end
        if (q0.size() >= 1) begin
            n_cmp++; if (q0[0] !== 32'h0000006b) begin n_err++; $display("FAIL fl_delim_word: got %h want 0000006b", q0[0]); end
        end
        n_cmp++; if (word_count !== 8'd6) begin n_err++; $display("FAIL fl_word_count: got %0d want 6", word_count); end
    endtask

    task automatic test_reset_mid();
        send_str("ab ");
        step(); step();
        n_cmp++; if (write_out !== 1'b1) begin n_err++; $display("FAIL rm_beat2_write: got %b want 1", write_out); end
        rst = 1'b1; step(); rst = 1'b0;
        n_cmp++; if (write_out !== 1'b0) begin n_err++; $display("FAIL rm_write: got %b want 0", write_out); end
        n_cmp++; if (word_count !== 8'd0) begin n_err++; $display("FAIL rm_word_count: got %0d want 0", word_count); end
        q0.delete();
        send_str("ab ");
        repeat (8) step();
        n_cmp++; if (q0.size() != 4) begin n_err++; $display("FAIL rm_beats: got %0d want 4", q0.size()); end
        if (q0.size() >= 1) begin
            n_cmp++; if (q0[0] !== 32'h00006261) begin n_err++; $display("FAIL rm_word: got %h want 00006261", q0[0]); end
        end
        n_cmp++; if (word_count !== 8'd1) begin n_err++; $display("FAIL rm_word_count_after: got %0d want 1", word_count); end
    endtask

    task automatic test_random_gap1();
        logic [127:0] exp_q[$];
        logic [127:0] mkey = '0;
        logic [127:0] tmp;
        logic [7:0]   alpha [6] = '{8'h61, 8'h62, 8'h63, 8'h20, 8'h0a, 8'h09};
        int           mlen = 0;
        int           exp_cnt = 0;
        q1.delete();
        for (int i = 0; i < 400; i++) begin
            c1_valid = ($urandom_range(0, 2) != 0);
            c1_char  = alpha[$urandom_range(0, 5)];
            if (c1_valid && c1_ready) begin
                if (c1_char == 8'h20 || c1_char == 8'h0a || c1_char == 8'h09 || c1_char == 8'h0d) begin
                    if (mlen > 0) begin
                        exp_q.push_back(mkey);
                        exp_cnt++;
                        mkey = '0;
                        mlen = 0;
                    end
                end else if (mlen < 16) begin
                    mkey[8*mlen +: 8] = c1_char;
                    mlen++;
                end
            end
            step();
        end
        c1_valid = 1'b0;
        repeat (12) step();
        n_cmp++; if (q1.size() != 4 * exp_q.size()) begin
            n_err++; $display("FAIL rnd_beats: got %0d want %0d", q1.size(), 4 * exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && 4*i+3 < q1.size(); i++) begin
            tmp = exp_q[i];
            for (int b = 0; b < 4; b++) begin
                n_cmp++; if (q1[4*i+b] !== tmp[32*b +: 32]) begin
                    n_err++; $display("FAIL rnd_word%0d_beat%0d: got %h want %h", i, b, q1[4*i+b], tmp[32*b +: 32]);
                end
            end
        end
        n_cmp++; if (c1_count !== 8'(exp_cnt)) begin
            n_err++; $display("FAIL rnd_word_count: got %0d want %0d", c1_count, exp_cnt % 256);
        end
    endtask

    initial begin
        test_reset();
        test_hi();
        test_trunc();
        test_multi_delim();
        test_flush();
        test_reset_mid();
        test_random_gap1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/word_mapper.md
# word_mapper

Map-stage front end of the MapReduce pipeline. It consumes a byte-serial text stream and splits it into whitespace-delimited words. Each word is zero-padded into a 128-bit key and emitted as four 32-bit beats on a `write_out`/`pair_out` strobe that connects directly to the reducer's `write_in`/`pair_in`. Inter-word gaps are inserted so the reducer can advance its row pointer between words.

## Interface
Parameters:
- `DATA_SIZE`, 32, beat width of `pair_out`
- `WORD_LENGTH`, 128, key width; max word length = WORD_LENGTH/8 = 16 chars
- `GAP_CYCLES`, 2, idle cycles forced after each emitted word (legal range 1..15)

Ports:
- `clk` in 1: the single clock
- `rst` in 1: reset, synchronous, active-high
- `char_in` in 8: ASCII input byte
- `char_valid` in 1: `char_in` valid
- `char_ready` out 1: block accepts a byte this cycle
- `flush` in 1: end-of-stream pulse; emit any pending partial word
- `write_out` out 1: beat valid, drives reducer `write_in`
- `pair_out` out DATA_SIZE: key beat, drives reducer `pair_in`
- `word_count` out 8: words emitted since reset, wraps at 255
- `trunc` out 1: sticky flag, set when any word exceeded 16 chars

## Operation
- A byte is accepted when `char_valid && char_ready` at a rising edge.
- Delimiters are 0x20, 0x09, 0x0A and 0x0D. Every other byte is a word character.
- Packing: char k (k = 0..15) is placed in key bits [8k+7:8k]; unused bytes are 0. Char 17 onward is discarded and `trunc` is set.
- States:
  - COLLECT: `char_ready`=1. A word char appends to the key and `len++`, saturating at 16. A delimiter with len>0 goes to EMIT. A delimiter with len=0 is consumed with no output, so repeated delimiters produce no empty keys.
  - EMIT: 4 cycles. `write_out`=1; `pair_out` = key[32b+31:32b] for b = 0,1,2,3 in order. `char_ready`=0. `word_count` increments on the beat-3 cycle.
  - GAP: `GAP_CYCLES` cycles. `write_out`=0, `pair_out`=0, `char_ready`=0. Then the key and len are cleared and the block returns to COLLECT.
- `flush` is sampled only in COLLECT; it is ignored elsewhere.
  - With len>0: goes to EMIT.
  - With len=0: no-op.
- `flush` and an accepted byte in the same cycle: the byte is applied first, then the flush. A word char is included in the emitted key. A delimiter plus flush results in exactly one emission.
- Emitted keys are never zero (len≥1). This is required because the reducer treats a 0 key as empty.

## Timing
- Reset (synchronous, `rst`=1 at an edge) forces the following; all outputs are registered except `char_ready` = (state==COLLECT):
  - state = COLLECT, key = 0, len = 0
  - `write_out`=0, `pair_out`=0
  - `word_count`=0, `trunc`=0
- Reset mid-EMIT or mid-GAP: `write_out` falls at that edge and the partial word is lost. The word is not counted.
- Latency: a terminating delimiter or flush accepted at edge t gives beats 0..3 valid in cycles t+1..t+4, then gap cycles t+5..t+4+GAP_CYCLES. `char_ready` is high again in cycle t+5+GAP_CYCLES.
- `write_out` is high for exactly 4 consecutive cycles per word and is low for ≥`GAP_CYCLES` cycles between words. Minimum word-to-word pitch is 4+GAP_CYCLES+1 cycles.
- `trunc` and `word_count` update on the edge ending the relevant cycle and are visible the next cycle.

## Structure
- The shared package `mr_pkg` holds:
  - `DATA_SIZE`, `WORD_LENGTH`
  - delimiter constants
  - the mapper state enum (COLLECT, EMIT, GAP)
  - the key typedef (`logic [WORD_LENGTH-1:0]`), which the reducer also uses
- One sub-module, `word_packer`: the key register, length counter, truncation detect and beat mux, selected by a 2-bit beat index.
- The FSM, gap counter and word counter stay in `word_mapper`.

## Test plan
- Send "hi " → one 4-beat burst: 0x00006968, 0, 0, 0; `word_count`=1; `trunc`=0; `char_ready` low for 4+2 cycles.
- Send "abcdefghijklmnopqrs " → beats 0x64636261, 0x68676665, 0x6c6b6a69, 0x706f6e6d; `trunc`=1.
- Send "  a   b\n" → exactly two bursts, with beat 0 = 0x00000061 and then 0x00000062; no all-zero burst; `write_out` low ≥2 cycles between bursts.
- Send "xyz" then a `flush` pulse → one burst with beat 0 = 0x007a7978. A second `flush` with len=0 produces no output.
- Assert `rst` during beat 2 of "ab " → `write_out`=0 next cycle, `word_count`=0. A subsequent "ab " emits 0x00006261 normally.
- Random `char_valid` with GAP_CYCLES=1, checked against a model → beats match and `word_count` matches the reference word count modulo 256.
